wb_car_pos_master: RTL and testbench

- Wishbone initiator that owns the player-car position and pushes it into the VGA peripheral's position register.
- Takes single-cycle move pulses from the input/debounce logic and updates a saturating X/Y position.
- Issues one Wishbone write per change to register offset 0x0. Layout: bits[9:0] = X, bits[19:10] = Y, upper bits zero.
- Sits between the button conditioning logic and the VGA peripheral's Wishbone slave port, in the wb_clk_i domain.

---
 rtl/wb_car_pos_master.sv | 190 +++++++++++++++++++
 tb/tb_wb_car_pos_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_car_pos_master.sv
// Wishbone initiator that owns the saturating car X/Y position and writes it to the VGA position register.
// Optional macro WB_CAR_READBACK_EN adds a verifying read after every acknowledged write.
module wb_car_pos_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [9:0]  X_INIT      = 10'd293,
    parameter logic [9:0]  Y_INIT      = 10'd429,
    parameter logic [9:0]  X_MIN       = 10'd200,
    parameter logic [9:0]  X_MAX       = 10'd400,
    parameter logic [9:0]  Y_MIN       = 10'd0,
    parameter logic [9:0]  Y_MAX       = 10'd429,
    parameter logic [9:0]  STEP        = 10'd4,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        btn_left_i,
    input  logic        btn_right_i,
    input  logic        btn_up_i,
    input  logic        btn_down_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic [9:0]  car_x_o,
    output logic [9:0]  car_y_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef WB_CAR_READBACK_EN
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_HOLD} state_t;
    logic        rd_after_q;
    logic [11:0] unused_dat;
    assign unused_dat = wb_dat_i[31:20];
`else
    typedef enum logic [1:0] {S_IDLE, S_WR, S_HOLD} state_t;
    logic [31:0] unused_dat;
    assign unused_dat = wb_dat_i;
`endif

    state_t          state_q;
    logic [9:0]      x_q, y_q, x_nxt, y_nxt;
    logic [10:0]     x_dec, x_inc, y_dec, y_inc;
    logic            moved, pending_q, timed_out;
    logic [TW-1:0]   timer_q;

    // 11-bit arithmetic exposes underflow (bit 10 set) and overflow before clamping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        x_dec = {1'b0, x_q} - {1'b0, STEP};
        x_inc = {1'b0, x_q} + {1'b0, STEP};
        y_dec = {1'b0, y_q} - {1'b0, STEP};
        y_inc = {1'b0, y_q} + {1'b0, STEP};
        x_nxt = x_q;
        y_nxt = y_q;
        if (btn_left_i && !btn_right_i)
            x_nxt = (x_dec[10] || x_dec[9:0] < X_MIN) ? X_MIN : x_dec[9:0];
        else if (btn_right_i && !btn_left_i)
            x_nxt = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[9:0];
        if (btn_up_i && !btn_down_i)
            y_nxt = (y_dec[10] || y_dec[9:0] < Y_MIN) ? Y_MIN : y_dec[9:0];
        else if (btn_down_i && !btn_up_i)
            y_nxt = (y_inc > {1'b0, Y_MAX}) ? Y_MAX : y_inc[9:0];
    end

    assign moved     = (x_nxt != x_q) || (y_nxt != y_q);
    assign timed_out = (timer_q == TIMER_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!wb_rst_ni) begin
            x_q <= X_INIT;
            y_q <= Y_INIT;
        end else begin
            x_q <= x_nxt;
            y_q <= y_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            err_o      <= 1'b0;
            pending_q  <= 1'b1;
            timer_q    <= '0;
`ifdef WB_CAR_READBACK_EN
            rd_after_q <= 1'b0;
`endif
        end else begin
            // A move in the launch cycle keeps pending set, so the newer value follows.
            pending_q <= pending_q | moved;
            case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b1;
                        wb_sel_o  <= 4'hF;
                        wb_adr_o  <= BASE_ADDR;
                        wb_dat_o  <= {12'b0, y_q, x_q};
                        pending_q <= moved;
                        timer_q   <= '0;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    if (wb_err_i || (!wb_ack_i && timed_out)) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= '0;
                        err_o     <= 1'b1;
                        pending_q <= 1'b1;
                        state_q   <= S_HOLD;
                    end else if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= '0;
                        state_q   <= S_HOLD;
`ifdef WB_CAR_READBACK_EN
                        rd_after_q <= 1'b1;
`endif
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
`ifdef WB_CAR_READBACK_EN
                S_RD: begin
                    if (wb_err_i || (!wb_ack_i && timed_out)) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= '0;
                        err_o     <= 1'b1;
                        pending_q <= 1'b1;
                        state_q   <= S_HOLD;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        if (wb_dat_i[19:0] != wb_dat_o[19:0]) err_o <= 1'b1;
                        state_q  <= S_HOLD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
`endif
                S_HOLD: begin
                    // The slave toggles its ack per request, so one dead cycle separates cycles.
`ifdef WB_CAR_READBACK_EN
                    if (rd_after_q) begin
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_we_o    <= 1'b0;
                        wb_sel_o   <= 4'hF;
                        wb_adr_o   <= BASE_ADDR;
                        timer_q    <= '0;
                        rd_after_q <= 1'b0;
                        state_q    <= S_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign car_x_o = x_q;
    assign car_y_o = y_q;
    assign busy_o  = wb_cyc_o;

endmodule

// File: tb/tb_wb_car_pos_master.sv
// Self-checking bench for wb_car_pos_master: directed moves, a responding Wishbone slave and a write scoreboard.
// Readback checks are compiled in when WB_CAR_READBACK_EN is defined.
module tb_wb_car_pos_master;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        btn_left_i, btn_right_i, btn_up_i, btn_down_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;
    logic [9:0]  car_x_o, car_y_o;
    logic        busy_o, err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    bit          ack_en    = 1'b1;
    int          ack_delay = 1;
    bit          err_once  = 1'b0;
    bit          rd_bad    = 1'b0;
    int          cnt       = 0;
    int          last_len  = 0;
    int          wr_starts = 0;
    int          wr_acks   = 0;
    logic [31:0] mem       = '0;
    int          x_m, y_m;

    wb_car_pos_master dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .btn_left_i (btn_left_i),
        .btn_right_i(btn_right_i),
        .btn_up_i   (btn_up_i),
        .btn_down_i (btn_down_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .car_x_o    (car_x_o),
        .car_y_o    (car_y_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [31:0] pack(input int y, input int x);
        logic [9:0] yy, xx;
        yy = y[9:0];
        xx = x[9:0];
        return {12'b0, yy, xx};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_model(input bit l, input bit r, input bit u, input bit d);
        if (l && !r)      x_m = (x_m - 4 < 200) ? 200 : x_m - 4;
        else if (r && !l) x_m = (x_m + 4 > 400) ? 400 : x_m + 4;
        if (u && !d)      y_m = (y_m - 4 < 0) ? 0 : y_m - 4;
        else if (d && !u) y_m = (y_m + 4 > 429) ? 429 : y_m + 4;
    endtask

    task automatic pulse(input bit l, input bit r, input bit u, input bit d);
        @(negedge wb_clk_i);
        btn_left_i = l; btn_right_i = r; btn_up_i = u; btn_down_i = d;
        step_model(l, r, u, d);
        @(negedge wb_clk_i);
        btn_left_i = 0; btn_right_i = 0; btn_up_i = 0; btn_down_i = 0;
    endtask

    // Wait until all expected writes are consumed and the bus has been quiet for 4 cycles.
    task automatic drain(input int budget);
        int quiet = 0;
        int n = 0;
        while (n < budget && !(quiet >= 4 && exp_q.size() == 0)) begin
            @(negedge wb_clk_i);
            n++;
            quiet = wb_cyc_o ? 0 : quiet + 1;
        end
        check("drain_done", {31'b0, (quiet >= 4 && exp_q.size() == 0)}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b0;
        ack_en = 1'b1;
        x_m = 293;
        y_m = 429;
        check("q_empty_at_reset", exp_q.size(), 32'd0);
        exp_q.push_back(pack(y_m, x_m));
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        drain(60);
    endtask

    // Slave: acks ack_delay+1 cycles after strobe, logs writes against the scoreboard.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
                cnt++;
                if (cnt == 1 && wb_we_o) wr_starts++;
                if (err_once && cnt > ack_delay) begin
                    wb_err_i = 1'b1;
                    wb_ack_i = 1'b1;
                    err_once = 1'b0;
                end else if (ack_en && cnt > ack_delay) begin
                    wb_ack_i = 1'b1;
                    if (wb_we_o) begin
                        check("wr_sel", {28'b0, wb_sel_o}, 32'hF);
                        check("wr_adr", wb_adr_o, BASE);
                        check("wr_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                        if (exp_q.size() != 0) check("wr_dat", wb_dat_o, exp_q.pop_front());
                        mem = wb_dat_o;
                        wr_acks++;
                    end else begin
                        wb_dat_i = rd_bad ? 32'h0 : mem;
                    end
                end
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                if (!wb_cyc_o && cnt != 0) begin
                    last_len = cnt;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        btn_left_i = 0; btn_right_i = 0; btn_up_i = 0; btn_down_i = 0;
        wb_rst_ni = 1'b0;
        x_m = 293;
        y_m = 429;
        #12;
        check("rst_car_x", {22'b0, car_x_o}, 32'd293);
        check("rst_car_y", {22'b0, car_y_o}, 32'd429);
        check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        check("rst_we", {31'b0, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_sel", {28'b0, wb_sel_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);

        // Initial-position write right after reset release.
        exp_q.push_back(pack(429, 293));
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        drain(60);
        check("init_cyc_len", last_len, 32'd2);
        check("init_wr_count", wr_acks, 32'd1);

        // Right pulse with latency check: cyc rises two cycles after the pulse cycle.
        pulse(0, 1, 0, 0);
        exp_q.push_back(pack(y_m, x_m));
        check("lat_cyc_n1", {31'b0, wb_cyc_o}, 32'd0);
        check("car_x_297", {22'b0, car_x_o}, 32'd297);
        @(negedge wb_clk_i);
        check("lat_cyc_n2", {31'b0, wb_cyc_o}, 32'd1);
        check("lat_busy_n2", {31'b0, busy_o}, 32'd1);
        check("lat_dat", wb_dat_o, pack(y_m, x_m));
        repeat (9) @(negedge wb_clk_i);
        for (int i = 0; i < 2; i++) begin
            pulse(0, 1, 0, 0);
            exp_q.push_back(pack(y_m, x_m));
            repeat (10) @(negedge wb_clk_i);
        end
        drain(60);
        check("car_x_305", {22'b0, car_x_o}, 32'd305);
        check("right_wr_count", wr_acks, 32'd4);

        // Walk left into X_MIN; the last step clamps 201 -> 200.
        while (x_m > 200) begin
            pulse(1, 0, 0, 0);
            exp_q.push_back(pack(y_m, x_m));
            repeat (12) @(negedge wb_clk_i);
        end
        drain(60);
        check("car_x_min", {22'b0, car_x_o}, 32'd200);

        // Pulses that change nothing must not launch a write.
        s = wr_starts;
        pulse(1, 0, 0, 0);
        repeat (10) @(negedge wb_clk_i);
        check("left_at_min_x", {22'b0, car_x_o}, 32'd200);
        check("left_at_min_nowr", wr_starts, s);
        pulse(1, 1, 0, 0);
        repeat (10) @(negedge wb_clk_i);
        check("lr_cancel_x", {22'b0, car_x_o}, 32'd200);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 1);
        repeat (10) @(negedge wb_clk_i);
        check("down_at_max_y", {22'b0, car_y_o}, 32'd429);
        check("cancel_nowr", wr_starts, s);
        pulse(0, 0, 1, 0);
        exp_q.push_back(pack(y_m, x_m));
        drain(60);
        check("car_y_up", {22'b0, car_y_o}, 32'd425);

        // Five consecutive right pulses against a slow slave coalesce into two writes.
        ack_delay = 8;
        s = wr_starts;
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            btn_right_i = 1'b1;
            step_model(0, 1, 0, 0);
            if (i == 0) exp_q.push_back(pack(y_m, x_m));
        end
        @(negedge wb_clk_i);
        btn_right_i = 1'b0;
        exp_q.push_back(pack(y_m, x_m));
        drain(200);
        check("coalesce_wr_starts", wr_starts - s, 32'd2);
        check("coalesce_car_x", {22'b0, car_x_o}, 32'd220);
        ack_delay = 1;

        // Slave never acks: timeout after 16 cycles, sticky error, retry after HOLD.
        ack_en = 1'b0;
        pulse(0, 1, 0, 0);
        for (int i = 0; i < 40 && !err_o; i++) @(negedge wb_clk_i);
        check("timeout_err", {31'b0, err_o}, 32'd1);
        @(negedge wb_clk_i);
        check("timeout_len", last_len, 32'd16);
        check("timeout_hold_cyc", {31'b0, wb_cyc_o}, 32'd0);
        @(negedge wb_clk_i);
        check("retry_cyc", {31'b0, wb_cyc_o}, 32'd1);
        check("retry_we", {31'b0, wb_we_o}, 32'd1);
        check("retry_dat", wb_dat_o, pack(y_m, x_m));
        #2 wb_rst_ni = 1'b0;
        #1;
        check("midrst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("midrst_err", {31'b0, err_o}, 32'd0);
        check("midrst_car_x", {22'b0, car_x_o}, 32'd293);
        do_reset();
        check("post_rst_err", {31'b0, err_o}, 32'd0);

        // ack and err together count as an error; the write is retried and lands.
        err_once = 1'b1;
        pulse(0, 1, 0, 0);
        exp_q.push_back(pack(y_m, x_m));
        drain(80);
        check("ackerr_err", {31'b0, err_o}, 32'd1);
        check("ackerr_car_x", {22'b0, car_x_o}, 32'd297);

`ifdef WB_CAR_READBACK_EN
        do_reset();
        pulse(0, 1, 0, 0);
        exp_q.push_back(pack(y_m, x_m));
        drain(80);
        check("rb_good_err", {31'b0, err_o}, 32'd0);
        rd_bad = 1'b1;
        pulse(0, 1, 0, 0);
        exp_q.push_back(pack(y_m, x_m));
        drain(80);
        check("rb_bad_err", {31'b0, err_o}, 32'd1);
        rd_bad = 1'b0;
`endif

        check("final_q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
